// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//
// This package holds the definitions that the spi_master and the existing
// spi slave share.
//   spi_state_e  : the master FSM states (IDLE, SETUP, HIGH, LOW).
//   spi_mode_t   : the clock polarity and phase pair.
//   SPI_MODE0    : CPOL=0, CPHA=0. The idle clock is low and data is sampled
//                  on the rising edge.
//   SPI_WIDTH    : the frame width in bits. The slave uses the same value.
//   div_width()  : the width of a counter that counts 0..div-1. It is never
//                  less than 1.
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};

    localparam int SPI_WIDTH = 8;

    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// This is a byte-wide SPI master. It runs in mode 0 and sends MSB first.
// The master and the slave share one clock, so miso is sampled directly,
// with no synchroniser.
//
// Parameters
//   CLK_DIV   : the sck half-period in clk cycles. The legal range is 2..255.
//
// Ports
//   clk       : system clock.
//   rst       : synchronous, active-high reset.
//   start     : transfer request. It is only looked at while busy is 0.
//   hold_ss   : sampled with start. When it is 1, ss stays low after the
//               byte, so the next byte continues the same frame.
//   din       : byte to send. Sampled with start.
//   dout      : last byte received. It updates with done.
//   done      : one-cycle pulse when a transfer completes.
//   busy      : high from the accepting edge until completion.
//   sck       : SPI clock. Idle low.
//   mosi      : master out.
//   miso      : master in.
//   ss        : slave select, active low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ss is high, or low if a burst is being held
// SETUP | ss is low, sck is low, waiting for ss-to-first-edge setup time
// HIGH  | sck is high; miso was captured on the entering edge
// LOW   | sck is low; mosi shows the next bit (after bit 7: hold time)
// ---------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hold_ss,
    input  logic [SPI_WIDTH-1:0] din,
    output logic [SPI_WIDTH-1:0] dout,
    output logic                 done,
    output logic                 busy,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ss
);

    localparam int DIV_W = div_width(int'(CLK_DIV));
    localparam int BIT_W = $clog2(SPI_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_WIDTH - 1);

    spi_state_e           state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [SPI_WIDTH-1:0] tx_sr;
    logic [SPI_WIDTH-1:0] rx_sr;
    logic                 hold_lat;
    logic                 phase_end;

    // Every phase lasts CLK_DIV cycles. div_cnt restarts at 0 on each
    // phase change.
    assign phase_end = (div_cnt == DIV_LAST);

    // mosi comes straight from the flop at the top of the transmit shifter.
    // Reset clears the shifter, so mosi idles at 0. The shifter is left
    // alone at completion, so the last bit is still driven during the
    // hold phase.
    assign mosi = tx_sr[SPI_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            hold_lat <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            sck      <= SPI_MODE0.cpol;
            ss       <= 1'b1;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        tx_sr    <= din;
                        hold_lat <= hold_ss;
                        busy     <= 1'b1;
                        ss       <= 1'b0;
                    end
                end

                SETUP: begin
                    if (phase_end) begin
                        state   <= HIGH;
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        // The sample is taken on the same edge that
                        // drives sck high.
                        rx_sr   <= {rx_sr[SPI_WIDTH-2:0], miso};
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                HIGH: begin
                    if (phase_end) begin
                        state   <= LOW;
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        // After bit 7 there is nothing left to present.
                        // mosi holds through the hold phase.
                        if (bit_cnt != BIT_LAST) begin
                            tx_sr <= {tx_sr[SPI_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                LOW: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            dout  <= rx_sr;
                            busy  <= 1'b0;
                            ss    <= ~hold_lat;
                        end else begin
                            state   <= HIGH;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sck     <= 1'b1;
                            rx_sr   <= {rx_sr[SPI_WIDTH-2:0], miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
